// File: rtl/sdpram_burst_reader_pkg.sv
// sdpram_pkg: shared definitions for the sdpram burst reader.
//   ADDR_W  default RAM address width (depth 2^ADDR_W)
//   DATA_W  default RAM word width
//   state_t burst reader FSM states
package sdpram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sdpram_burst_reader_if.sv
// sdpram_burst_reader_if: valid/ready stream carrying RAM words from the
// burst reader to its downstream consumer.
//   m_valid  stream data valid (master -> slave)
//   m_data   stream data word  (master -> slave)
//   m_ready  consumer ready    (slave -> master)
// Modports: master (burst reader side), slave (consumer side).
interface sdpram_burst_reader_if
  import sdpram_pkg::*;
#(
  parameter int DATA_W = sdpram_pkg::DATA_W
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/sdpram_burst_reader_rd_skid_fifo.sv
// rd_skid_fifo: 2-entry synchronous FIFO that absorbs the RAM's one-cycle
// read latency between the read issue logic and the output stream.
//   clk, rst_n  clock, asynchronous active-low reset
//   push/wdata  write a word (the RAM data returning this cycle)
//   pop         remove the head word
//   flush       empty the FIFO; takes priority over push and pop
//   rdata       head word (held stable until popped)
//   valid       FIFO holds at least one word
//   count       current occupancy, 0..2
module rd_skid_fifo
  import sdpram_pkg::*;
#(
  parameter int DATA_W = sdpram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Storage and pointers. The issue logic upstream guarantees a push never
  // arrives while the FIFO is full, so no full guard is needed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/sdpram_burst_reader.sv
// sdpram_burst_reader: burst read engine for the 256x16 simple dual-port RAM.
// Accepts a (base_addr, length) command, issues RAM reads, buffers the
// returning data in a 2-entry FIFO and presents it as a valid/ready stream.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        command strobe, sampled only in IDLE
//   base_addr    first read address
//   length       beat count, 0..2^ADDR_W
//   abort        cancel the running burst (only with READER_ABORT_EN)
//   busy         burst in progress (READ or DRAIN)
//   done         one-cycle completion pulse
//   enb, addrb   RAM read enable / address
//   ram_rdata    RAM read data, valid the cycle after enb
//   m_if         output stream (master modport)
// Optional feature macro: READER_ABORT_EN adds the abort port.
// Integration note: enb depends combinationally on m_if.m_ready.
module sdpram_burst_reader
  import sdpram_pkg::*;
#(
  parameter int ADDR_W = sdpram_pkg::ADDR_W,
  parameter int DATA_W = sdpram_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
`ifdef READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [ADDR_W-1:0]     addrb,
  input  logic [DATA_W-1:0]     ram_rdata,
  sdpram_burst_reader_if.master m_if
);

  localparam logic [ADDR_W:0] ONE_BEAT = 1;

  state_t            state;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   beat_left;
  logic              inflight;
  logic [1:0]        occupancy;
  logic [2:0]        credit_used;
  logic              pop;
  logic              flush;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_rdata;

  assign pop = fifo_valid && m_if.m_ready;

`ifdef READER_ABORT_EN
  assign flush = abort && busy;
`else
  assign flush = 1'b0;
`endif

  // A read may only be issued when the words already buffered plus the one
  // in flight, less the one leaving this cycle, leave room for it.
  always_comb begin
    credit_used = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
    enb         = (state == READ) && (credit_used < 3'd2);
  end

  // FSM, address counter and issue/beat counters. An abort discards the
  // in-flight read by clearing inflight so its data is never pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      addrb      <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= enb && !flush;
      done     <= 1'b0;
      if (enb) begin
        addrb      <= addrb + 1'b1;
        issue_left <= issue_left - ONE_BEAT;
      end
      if (pop) begin
        beat_left <= beat_left - ONE_BEAT;
      end
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (length != '0) begin
                state      <= READ;
                busy       <= 1'b1;
                addrb      <= base_addr;
                issue_left <= length;
                beat_left  <= length;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          READ: begin
            if (enb && (issue_left == ONE_BEAT)) begin
              state <= DRAIN;
            end
          end
          // The last beat leaving means nothing is in flight or buffered.
          DRAIN: begin
            if (pop && (beat_left == ONE_BEAT)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  rd_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata (ram_rdata),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (occupancy)
  );

  assign m_if.m_valid = fifo_valid;
  assign m_if.m_data  = fifo_rdata;

endmodule

// File: tb/tb_sdpram_burst_reader.sv
// tb_sdpram_burst_reader: directed self-checking bench for sdpram_burst_reader.
// Models the RAM read port (RAM[i] = i*3, 1-cycle latency) and drives bursts
// with hand-computed expected data, addresses and cycle numbers. Cycle c is
// the clock period following the c-th rising edge after the start edge.
// Optional feature macro: READER_ABORT_EN enables the abort scenario.
module tb_sdpram_burst_reader;
  import sdpram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic        enb;
  logic [7:0]  addrb;
  logic [15:0] ram_rdata;
  logic        m_ready;
`ifdef READER_ABORT_EN
  logic        abort;
`endif

  logic [15:0] ram [256];

  int          test_count = 0;
  int          fail_count = 0;

  logic [15:0] rx_data [$];
  int          rx_cyc [$];
  logic [7:0]  addr_q [$];
  int          first_enb;
  int          done_cycle;
  int          done_count;
  int          stall_err;
  int          valid_count;
  int          valid_after_abort;
  int          enb_count;
  logic        busy_at [64];
  bit          ovf_seen = 1'b0;
  int          max_occ = 0;

  sdpram_burst_reader_if #(.DATA_W(16)) m_if ();

  assign m_if.m_ready = m_ready;

  sdpram_burst_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef READER_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .ram_rdata (ram_rdata),
    .m_if      (m_if)
  );

  always #5 clk = ~clk;

  // RAM read port model: data appears the cycle after enb.
  always @(posedge clk) begin
    if (enb) begin
      ram_rdata <= ram[addrb];
    end
  end

  // FIFO occupancy watch: track the peak and flag a push into a full FIFO.
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(dut.u_fifo.count) > max_occ) begin
        max_occ = int'(dut.u_fifo.count);
      end
      if (dut.u_fifo.count == 2'd2 && dut.u_fifo.push && !dut.u_fifo.pop) begin
        ovf_seen = 1'b1;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},    32'(busy),         32'h0);
    checkOutput({tag, "_done"},    32'(done),         32'h0);
    checkOutput({tag, "_enb"},     32'(enb),          32'h0);
    checkOutput({tag, "_addrb"},   32'(addrb),        32'h0);
    checkOutput({tag, "_m_valid"}, 32'(m_if.m_valid), 32'h0);
    checkOutput({tag, "_m_data"},  32'(m_if.m_data),  32'h0);
  endtask

  // Issue one command and record what the DUT does for ncycles cycles.
  // ready_mode 1: m_ready held high; 0: m_ready high on odd cycles only.
  task automatic applyStimulus(input logic [7:0] b, input logic [8:0] len,
                               input int ready_mode, input int ncycles,
                               input int abort_cycle);
    logic        prev_stall;
    logic [15:0] prev_data;
    rx_data.delete();
    rx_cyc.delete();
    addr_q.delete();
    first_enb         = -1;
    done_cycle        = -1;
    done_count        = 0;
    stall_err         = 0;
    valid_count       = 0;
    valid_after_abort = 0;
    enb_count         = 0;
    for (int i = 0; i < 64; i++) begin
      busy_at[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = len;
    @(posedge clk);
    #1;
    start      = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 1; c <= ncycles; c++) begin
      m_ready = (ready_mode == 1) ? 1'b1 : c[0];
`ifdef READER_ABORT_EN
      abort = (c == abort_cycle);
`endif
      @(negedge clk);
      if (c < 64) begin
        busy_at[c] = busy;
      end
      if (enb) begin
        enb_count++;
        addr_q.push_back(addrb);
        if (first_enb < 0) begin
          first_enb = c;
        end
      end
      if (m_if.m_valid) begin
        valid_count++;
        if (c > abort_cycle) begin
          valid_after_abort++;
        end
      end
      if (prev_stall && (!m_if.m_valid || m_if.m_data !== prev_data)) begin
        stall_err++;
      end
      if (m_if.m_valid && m_ready) begin
        rx_data.push_back(m_if.m_data);
        rx_cyc.push_back(c);
      end
      prev_stall = m_if.m_valid && !m_ready;
      prev_data  = m_if.m_data;
      if (done) begin
        done_count++;
        if (done_cycle < 0) begin
          done_cycle = c;
        end
      end
      if (c < ncycles) begin
        @(posedge clk);
        #1;
      end
    end
    m_ready = 1'b1;
`ifdef READER_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  initial begin
    logic [15:0] exp_t2 [4];
    logic [7:0]  exp_a2 [4];
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'(i * 3);
    end
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;
`ifdef READER_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Basic burst: base 0x10, 4 beats, consumer always ready.
    applyStimulus(8'h10, 9'd4, 1, 9, 1000);
    checkOutput("t1_first_enb",   32'(first_enb),     32'd1);
    checkOutput("t1_beats",       32'(rx_data.size()), 32'd4);
    checkOutput("t1_first_valid", 32'(rx_cyc[0]),     32'd3);
    checkOutput("t1_last_valid",  32'(rx_cyc[3]),     32'd6);
    checkOutput("t1_beat0",       32'(rx_data[0]),    32'h30);
    checkOutput("t1_beat1",       32'(rx_data[1]),    32'h33);
    checkOutput("t1_beat2",       32'(rx_data[2]),    32'h36);
    checkOutput("t1_beat3",       32'(rx_data[3]),    32'h39);
    checkOutput("t1_done_cycle",  32'(done_cycle),    32'd7);
    checkOutput("t1_done_count",  32'(done_count),    32'd1);
    checkOutput("t1_busy_c6",     32'(busy_at[6]),    32'd1);
    checkOutput("t1_busy_c8",     32'(busy_at[8]),    32'd0);

    // Address wrap: 0xFE, 0xFF, 0x00, 0x01.
    applyStimulus(8'hFE, 9'd4, 1, 9, 1000);
    exp_a2 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_t2 = '{16'h02FA, 16'h02FD, 16'h0000, 16'h0003};
    checkOutput("t2_enb_count", 32'(enb_count),      32'd4);
    checkOutput("t2_beats",     32'(rx_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_addr%0d", k), 32'(addr_q[k]),  32'(exp_a2[k]));
      checkOutput($sformatf("t2_beat%0d", k), 32'(rx_data[k]), 32'(exp_t2[k]));
    end
    checkOutput("t2_done_cycle", 32'(done_cycle), 32'd7);

    // Backpressure: m_ready toggles every cycle, 8 beats from 0x20.
    max_occ  = 0;
    ovf_seen = 1'b0;
    applyStimulus(8'h20, 9'd8, 0, 40, 1000);
    checkOutput("t3_beats", 32'(rx_data.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t3_beat%0d", k), 32'(rx_data[k]), 32'(16'h60 + 16'(3 * k)));
    end
    checkOutput("t3_stall_stable", 32'(stall_err),       32'd0);
    checkOutput("t3_no_overflow",  32'(ovf_seen),        32'd0);
    checkOutput("t3_max_occ_le2",  32'(max_occ <= 2),    32'd1);
    checkOutput("t3_done_count",   32'(done_count),      32'd1);
    checkOutput("t3_done_seen",    32'(done_cycle > 0),  32'd1);

    // Zero-length command.
    applyStimulus(8'h33, 9'd0, 1, 4, 1000);
    checkOutput("t4_done_cycle", 32'(done_cycle),  32'd1);
    checkOutput("t4_enb_count",  32'(enb_count),   32'd0);
    checkOutput("t4_valid",      32'(valid_count), 32'd0);
    checkOutput("t4_busy_c1",    32'(busy_at[1]),  32'd0);

    // Reset at beat 3 of a 10-beat burst, then a clean burst.
    applyStimulus(8'h40, 9'd10, 1, 5, 1000);
    checkOutput("t5_pre_beats", 32'(rx_data.size()), 32'd3);
    checkOutput("t5_pre_beat2", 32'(rx_data[2]),     32'hC6);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("t5_midreset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h50, 9'd3, 1, 8, 1000);
    checkOutput("t5_beats",      32'(rx_data.size()), 32'd3);
    checkOutput("t5_beat0",      32'(rx_data[0]),     32'hF0);
    checkOutput("t5_beat1",      32'(rx_data[1]),     32'hF3);
    checkOutput("t5_beat2",      32'(rx_data[2]),     32'hF6);
    checkOutput("t5_done_cycle", 32'(done_cycle),     32'd6);

`ifdef READER_ABORT_EN
    // Abort in cycle 4 of a 16-beat burst, then a follow-up burst.
    applyStimulus(8'h80, 9'd16, 1, 12, 4);
    checkOutput("t6_valid_after", 32'(valid_after_abort), 32'd0);
    checkOutput("t6_done_count",  32'(done_count),        32'd0);
    checkOutput("t6_beats",       32'(rx_data.size()),    32'd2);
    checkOutput("t6_busy_c5",     32'(busy_at[5]),        32'd0);
    applyStimulus(8'h02, 9'd2, 1, 7, 1000);
    checkOutput("t6_next_beats",  32'(rx_data.size()), 32'd2);
    checkOutput("t6_next_beat0",  32'(rx_data[0]),     32'h6);
    checkOutput("t6_next_beat1",  32'(rx_data[1]),     32'h9);
    checkOutput("t6_next_done",   32'(done_cycle),     32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
